host_wr_queue: RTL

- Write-buffering stage between host_interface and the vram write port.
- Accepts single-cycle host write requests (hostAddr, hostWrData, hostWr) into a small FIFO.
- Drains the FIFO into vram at most one write per clk, only in cycles where drainEn is high.
- drainEn is driven at top level, typically from blanking (nVis) or readout idle (!active).

---
 rtl/host_wr_queue_if.sv | 30 +++
 rtl/host_wr_queue.sv | 107 ++++++++++
 2 files changed

// File: rtl/host_wr_queue_if.sv
// Host-write / vram-write bundle for host_wr_queue: host side drives requests,
// queue side returns the registered vram write and occupancy status.
interface host_wr_queue_if #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 2
);
    logic [ADDR_W-1:0]     hostAddr;
    logic [DATA_W-1:0]     hostWrData;
    logic                  hostWr;
    logic                  drainEn;
    logic                  clrOvf;
    logic [ADDR_W-1:0]     vramAddr;
    logic [DATA_W-1:0]     vramWrData;
    logic                  vramWr;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;

    modport master (
        output hostAddr, hostWrData, hostWr, drainEn, clrOvf,
        input  vramAddr, vramWrData, vramWr, full, empty, level, overflow
    );

    modport slave (
        input  hostAddr, hostWrData, hostWr, drainEn, clrOvf,
        output vramAddr, vramWrData, vramWr, full, empty, level, overflow
    );
endinterface

// File: rtl/host_wr_queue.sv
// Small write FIFO between host and vram, drained one entry per enabled cycle.
// Optional HOSTWR_COALESCE_EN merges back-to-back writes to the same address.
module host_wr_queue #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input logic            clk,
    input logic            rst,
    host_wr_queue_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic [ADDR_W-1:0]     vaddr_q, vaddr_d;
    logic [DATA_W-1:0]     vdata_q, vdata_d;
    logic                  vwr_q, vwr_d;

    logic full, empty, deq, enq, drop, coal;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign deq   = bus.drainEn & !empty;

`ifdef HOSTWR_COALESCE_EN
    logic [DEPTH_LOG2-1:0] tail;
    assign tail = wptr_q - PTR_ONE;
    // A single entry that is leaving this cycle cannot absorb new data.
    assign coal = bus.hostWr & !empty & (bus.hostAddr == addr_mem[tail])
                & !((level_q == LVL_ONE) & deq);
`else
    assign coal = 1'b0;
`endif

    assign enq  = bus.hostWr & !coal & (!full | deq);
    assign drop = bus.hostWr & !coal & full & !deq;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        vaddr_d = vaddr_q;
        vdata_d = vdata_q;
        vwr_d   = deq;
        if (enq) wptr_d = wptr_q + PTR_ONE;
        if (deq) begin
            rptr_d  = rptr_q + PTR_ONE;
            vaddr_d = addr_mem[rptr_q];
            vdata_d = data_mem[rptr_q];
        end
        if (enq && !deq) level_d = level_q + LVL_ONE;
        if (deq && !enq) level_d = level_q - LVL_ONE;
        // Set has priority over clear.
        if (bus.clrOvf) ovf_d = 1'b0;
        if (drop)       ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            vaddr_q <= '0;
            vdata_q <= '0;
            vwr_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            vaddr_q <= vaddr_d;
            vdata_q <= vdata_d;
            vwr_q   <= vwr_d;
        end
    end

    // Storage is never reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wptr_q] <= bus.hostAddr;
            data_mem[wptr_q] <= bus.hostWrData;
        end
`ifdef HOSTWR_COALESCE_EN
        else if (coal) begin
            data_mem[tail] <= bus.hostWrData;
        end
`endif
    end

    assign bus.vramAddr   = vaddr_q;
    assign bus.vramWrData = vdata_q;
    assign bus.vramWr     = vwr_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.level      = level_q;
    assign bus.overflow   = ovf_q;
endmodule
